// File: rtl/if_fetch.sv
// Instruction fetch stage: owns the PC and the IF/ID pipeline register.
// Redirects come from EX (branch) or ID (j/jal/jr). A misaligned target halts the stage.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jump,
    input  logic        jr,
    input  logic [31:0] jr_target,
    output logic [31:0] id_instr,
    output logic [5:0]  id_opcode,
    output logic [5:0]  id_funct,
    output logic [31:0] id_pc_plus4,
    output logic        id_valid,
    output logic [31:0] fetch_cnt,
    output logic        addr_err
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t      state, state_nx;
    logic [31:0] pc, pc_nx;
    logic [31:0] instr_nx, pc4_nx, cnt_nx;
    logic        valid_nx, err_nx;

    logic        redir, seq;
    logic [31:0] target;
    logic [31:0] pc_plus4;

    assign imem_addr = pc;
    assign id_opcode = id_instr[31:26];
    assign id_funct  = id_instr[5:0];
    assign pc_plus4  = pc + 32'd4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            pc          <= RESET_PC;
            id_instr    <= '0;
            id_pc_plus4 <= '0;
            id_valid    <= 1'b0;
            fetch_cnt   <= '0;
            addr_err    <= 1'b0;
        end else begin
            state       <= state_nx;
            pc          <= pc_nx;
            id_instr    <= instr_nx;
            id_pc_plus4 <= pc4_nx;
            id_valid    <= valid_nx;
            fetch_cnt   <= cnt_nx;
            addr_err    <= err_nx;
        end
    end

    // Branch beats stall; a held stall freezes everything, including any pending jump in ID.
    always_comb begin
        redir  = 1'b0;
        seq    = 1'b0;
        target = '0;
        if (state == RUN) begin
            if (br_taken) begin
                redir  = 1'b1;
                target = br_target;
            end else if (!stall) begin
                if (jr && id_valid) begin
                    redir  = 1'b1;
                    target = jr_target;
                end else if (jump && id_valid) begin
                    redir  = 1'b1;
                    target = {id_pc_plus4[31:28], id_instr[25:0], 2'b00};
                end else begin
                    seq = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        instr_nx = id_instr;
        pc4_nx   = id_pc_plus4;
        valid_nx = id_valid;
        cnt_nx   = fetch_cnt;
        err_nx   = addr_err;
        if (state == HALT || redir) begin
            instr_nx = '0;
            pc4_nx   = '0;
            valid_nx = 1'b0;
        end
        // A misaligned target leaves the PC where it was and parks the stage until reset.
        if (redir) begin
            if (target[1:0] != 2'b00) begin
                err_nx   = 1'b1;
                state_nx = HALT;
            end else begin
                pc_nx = target;
            end
        end else if (seq) begin
            pc_nx    = pc_plus4;
            instr_nx = imem_data;
            pc4_nx   = pc_plus4;
            valid_nx = 1'b1;
            cnt_nx   = fetch_cnt + 32'd1;
        end
    end

endmodule
